vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Top-level sequencing controller for the coin-operated vending datapath.
- Accumulates credit from single-cycle coin pulses and issues a req/ack vend handshake to the product dispenser.
- Pays out change, or refunds on cancel or vend timeout, one coin at a time over a req/ack handshake to the coin hopper.
- Price is a build parameter.

Parameters:
- PRICE, 5, item price in nickel units (5 = 25c); legal range 1..20.
- CREDIT_W, 5, credit register width in nickel units; must hold PRICE+4.
- VEND_TIMEOUT, 255, cycles vend_req may stay unacknowledged before a fault/refund; minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- nickel  in  1  single-cycle pulse, 5c inserted
- dime  in  1  single-cycle pulse, 10c inserted
- quarter  in  1  single-cycle pulse, 25c inserted
- cancel  in  1  level, customer refund request
- vend_ack  in  1  dispenser accepted vend (single-cycle pulse)
- chg_ack  in  1  hopper ejected requested coin (single-cycle pulse)
- vend_req  out  1  dispense one item
- chg_nickel_req  out  1  eject one nickel
- chg_dime_req  out  1  eject one dime
- coin_reject  out  1  registered one-cycle pulse, coin returned via reject chute
- vend_fault  out  1  registered one-cycle pulse, vend timed out
- busy  out  1  state != COLLECT
- credit  out  CREDIT_W  current credit in nickels

Behaviour:
- Reset (async): state = COLLECT, credit = 0, timer = 0, all outputs 0. Reset mid-handshake drops every req immediately; no payout resumes.
- Coin values: nickel = 1, dime = 2, quarter = 5.
- Coin acceptance:
  - Accepted only in COLLECT with exactly one coin pulse high.
  - A coin pulse in any other state, or two or more coin pulses in the same cycle, is not credited. coin_reject pulses the following cycle; credit is unchanged.
- COLLECT:
  - On an accepted coin, new = credit + value.
  - If new >= PRICE: credit <= new - PRICE, state <= VEND, timer <= 0. vend_req is high the cycle after the coin pulse.
  - Otherwise credit <= new.
  - cancel with credit > 0 and no accepted coin: state <= CHG_REQ, credit is retained as the refund.
  - A coin and cancel in the same cycle: the coin wins; cancel is ignored that cycle.
  - cancel with credit = 0: no effect.
- VEND:
  - vend_req = 1, held until vend_ack.
  - On vend_ack: state <= CHG_REQ if credit > 0, else COLLECT.
  - The timer increments each cycle in VEND. When it reaches VEND_TIMEOUT-1 without vend_ack: credit <= credit + PRICE, vend_fault pulses, state <= CHG_REQ.
  - vend_ack on the timeout cycle takes priority: normal completion, no fault.
  - cancel is ignored.
- CHG_REQ:
  - chg_dime_req = (credit >= 2); chg_nickel_req = (credit == 1). The two are never high together.
  - On chg_ack: credit decrements by 2 (dime) or 1 (nickel), state <= CHG_GAP.
- CHG_GAP:
  - All reqs are low for exactly one cycle.
  - Then state <= CHG_REQ if credit > 0, else COLLECT.
  - cancel is ignored.
- Acks:
  - vend_ack or chg_ack arriving when the matching req is low is ignored.
  - Acks are sampled on the same edge the req is observed high (zero-wait ack permitted).
- Payout order is greedy: dimes first, then at most one nickel.
- credit never exceeds PRICE+4; arithmetic is unsigned CREDIT_W bits; no wrap is possible by construction.

Decomposition:
- Shared package vend_pkg:
  - State enum: COLLECT, VEND, CHG_REQ, CHG_GAP (2-bit).
  - Coin value constants: NICKEL_VAL = 1, DIME_VAL = 2, QUARTER_VAL = 5.
- Sub-module change_payout:
  - Owns the CHG_REQ/CHG_GAP handshake and the coin-selection decrement.
  - Loaded with an amount plus a start strobe; returns done.
  - Reused later for the service-mode cash-out path.

Test Plan:
- quarter pulse at credit 0 -> next cycle vend_req=1, credit=0; vend_ack -> COLLECT, no chg req, busy=0.
- dime, dime, dime -> credit 2, 4, then vend_req with credit=1; vend_ack -> chg_nickel_req; chg_ack -> one-cycle gap, credit=0, COLLECT.
- dime then quarter -> credit 2, then vend with credit=2; after vend_ack -> exactly one chg_dime_req/ack; CHG_GAP shows reqs low for one cycle.
- nickel, dime, then cancel -> credit 3 refunded as dime then nickel; a quarter pulsed during refund -> coin_reject next cycle, credit unaffected.
- quarter, vend_ack withheld 255 cycles -> vend_fault one-cycle pulse, refund 5 = dime, dime, nickel; vend_ack on the final cycle instead -> no fault, no refund.
- nickel+dime in same cycle -> coin_reject, credit stays 0; async reset asserted while chg_dime_req=1 -> all outputs 0 immediately, credit=0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending sequencer and its payout engine.
// Coin values are in nickel units so credit arithmetic stays small and unsigned.
package vend_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      VEND    = 2'd1,
      CHG_REQ = 2'd2,
      CHG_GAP = 2'd3
   } state_t;

   localparam int NICKEL_VAL  = 1;
   localparam int DIME_VAL    = 2;
   localparam int QUARTER_VAL = 5;

   // Value of a single inserted coin; callers must first confirm exactly one pulse is high.
   function automatic int coin_value(input logic nickel, input logic dime, input logic quarter);
      int v;
      v = 0;
      if (nickel)  v = NICKEL_VAL;
      if (dime)    v = DIME_VAL;
      if (quarter) v = QUARTER_VAL;
      return v;
   endfunction

endpackage

// File: rtl/change_payout.sv
// Coin-at-a-time payout engine: greedy dimes then at most one nickel, with a
// one-cycle all-low gap after every hopper ack. Loaded by start+amount, signals done.
module change_payout
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CREDIT_W-1:0] amount,
   input  logic                chg_ack,
   output logic                chg_nickel_req,
   output logic                chg_dime_req,
   output logic [CREDIT_W-1:0] remaining,
   output logic                active,
   output logic                done
);

   localparam logic [CREDIT_W-1:0] DIME_AMT   = CREDIT_W'(DIME_VAL);
   localparam logic [CREDIT_W-1:0] NICKEL_AMT = CREDIT_W'(NICKEL_VAL);

   // COLLECT doubles as the idle state of this engine.
   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] amt_q, amt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= COLLECT;
         amt_q   <= '0;
      end else begin
         state_q <= state_d;
         amt_q   <= amt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      amt_d   = amt_q;
      case (state_q)
         COLLECT: begin
            if (start && (amount != '0)) begin
               amt_d   = amount;
               state_d = CHG_REQ;
            end
         end
         CHG_REQ: begin
            if (chg_ack) begin
               amt_d   = (amt_q >= DIME_AMT) ? (amt_q - DIME_AMT) : (amt_q - NICKEL_AMT);
               state_d = CHG_GAP;
            end
         end
         CHG_GAP: begin
            state_d = (amt_q != '0) ? CHG_REQ : COLLECT;
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_comb begin
      chg_dime_req   = (state_q == CHG_REQ) && (amt_q >= DIME_AMT);
      chg_nickel_req = (state_q == CHG_REQ) && (amt_q == NICKEL_AMT);
      remaining      = amt_q;
      active         = (state_q != COLLECT);
      done           = (state_q == CHG_GAP) && (amt_q == '0);
   end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: collects coin credit, runs the vend handshake with timeout,
// and hands change/refunds to change_payout. Coin pulses outside COLLECT are rejected.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE        = 5,
   parameter int CREDIT_W     = 5,
   parameter int VEND_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                nickel,
   input  logic                dime,
   input  logic                quarter,
   input  logic                cancel,
   input  logic                vend_ack,
   input  logic                chg_ack,
   output logic                vend_req,
   output logic                chg_nickel_req,
   output logic                chg_dime_req,
   output logic                coin_reject,
   output logic                vend_fault,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   localparam int                  TIMER_W    = $clog2(VEND_TIMEOUT);
   localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(VEND_TIMEOUT - 1);
   localparam logic [CREDIT_W-1:0] PRICE_AMT  = CREDIT_W'(PRICE);

   // CHG_REQ here means "payout engine owns the credit"; the engine tracks REQ vs GAP itself.
   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                coin_reject_q, coin_reject_d;
   logic                vend_fault_q, vend_fault_d;

   logic [1:0]          coin_cnt;
   logic                coin_any;
   logic                coin_ok;
   logic [CREDIT_W-1:0] coin_amt;
   logic [CREDIT_W-1:0] sum;

   logic                pay_start;
   logic [CREDIT_W-1:0] pay_amount;
   logic [CREDIT_W-1:0] pay_remaining;
   logic                pay_active;
   logic                pay_done;

   change_payout #(
      .CREDIT_W (CREDIT_W)
   ) u_payout (
      .clk            (clk),
      .reset          (reset),
      .start          (pay_start),
      .amount         (pay_amount),
      .chg_ack        (chg_ack),
      .chg_nickel_req (chg_nickel_req),
      .chg_dime_req   (chg_dime_req),
      .remaining      (pay_remaining),
      .active         (pay_active),
      .done           (pay_done)
   );

   always_comb begin
      coin_cnt = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
      coin_any = nickel | dime | quarter;
      coin_ok  = (state_q == COLLECT) && (coin_cnt == 2'd1);
      coin_amt = CREDIT_W'(coin_value(nickel, dime, quarter));
      sum      = credit_q + coin_amt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= COLLECT;
         credit_q      <= '0;
         timer_q       <= '0;
         coin_reject_q <= 1'b0;
         vend_fault_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         timer_q       <= timer_d;
         coin_reject_q <= coin_reject_d;
         vend_fault_q  <= vend_fault_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      timer_d       = timer_q;
      pay_start     = 1'b0;
      pay_amount    = credit_q;
      vend_fault_d  = 1'b0;
      coin_reject_d = coin_any && !coin_ok;
      case (state_q)
         COLLECT: begin
            if (coin_ok) begin
               if (sum >= PRICE_AMT) begin
                  credit_d = sum - PRICE_AMT;
                  state_d  = VEND;
                  timer_d  = '0;
               end else begin
                  credit_d = sum;
               end
            end else if (cancel && (credit_q != '0)) begin
               pay_start = 1'b1;
               credit_d  = '0;
               state_d   = CHG_REQ;
            end
         end
         VEND: begin
            if (vend_ack) begin
               if (credit_q != '0) begin
                  pay_start = 1'b1;
                  credit_d  = '0;
                  state_d   = CHG_REQ;
               end else begin
                  state_d = COLLECT;
               end
            end else if (timer_q == TIMER_LAST) begin
               // Timed out: refund the price along with any change still owed.
               pay_amount   = credit_q + PRICE_AMT;
               pay_start    = 1'b1;
               credit_d     = '0;
               vend_fault_d = 1'b1;
               state_d      = CHG_REQ;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         CHG_REQ: begin
            if (pay_done) begin
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_comb begin
      vend_req    = (state_q == VEND);
      busy        = (state_q != COLLECT);
      credit      = pay_active ? pay_remaining : credit_q;
      coin_reject = coin_reject_q;
      vend_fault  = vend_fault_q;
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized scoreboard bench for vend_sequencer: stimulus pushes expected vend,
// change-coin, reject and fault events; a negedge monitor pops and compares them.
module tb_vend_sequencer;

   localparam int PRICE    = 5;
   localparam int CREDIT_W = 5;
   localparam int VT       = 255;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
   logic                vend_ack = 1'b0, chg_ack = 1'b0;
   logic                vend_req, chg_nickel_req, chg_dime_req, coin_reject, vend_fault, busy;
   logic [CREDIT_W-1:0] credit;

   vend_sequencer #(
      .PRICE        (PRICE),
      .CREDIT_W     (CREDIT_W),
      .VEND_TIMEOUT (VT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .nickel         (nickel),
      .dime           (dime),
      .quarter        (quarter),
      .cancel         (cancel),
      .vend_ack       (vend_ack),
      .chg_ack        (chg_ack),
      .vend_req       (vend_req),
      .chg_nickel_req (chg_nickel_req),
      .chg_dime_req   (chg_dime_req),
      .coin_reject    (coin_reject),
      .vend_fault     (vend_fault),
      .busy           (busy),
      .credit         (credit)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int exp_vend_q[$];   // credit expected while vend_req first shows
   int exp_chg_q[$];    // coin value of each hopper request, in order
   int exp_rej_q[$];
   int exp_fault_q[$];

   int model_credit = 0;
   int vend_hold    = 0; // 0 random ack, 1 never ack, 2 ack on last legal cycle
   int chg_hold     = 0;
   int coin_vals[3] = '{1, 2, 5};

   int v_wait = 0, v_run = 0, c_wait = 0;
   int m_vrun = 0, m_last_run = 0;
   logic m_vprev = 1'b0, m_cprev = 1'b0, m_gap_due = 1'b0, m_creq;
   int r_sel, k_sel;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Dispenser model: random 0..3 cycle ack latency unless told to hold.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         vend_ack = 1'b0;
         if (reset || !vend_req) begin
            v_run = 0;
         end else begin
            v_run++;
            if (vend_hold == 0) begin
               if (v_wait == 0) begin
                  vend_ack = 1'b1;
                  v_wait   = $urandom_range(0, 3);
               end else begin
                  v_wait--;
               end
            end else if (vend_hold == 2 && v_run == VT) begin
               vend_ack = 1'b1;
            end
         end
      end
   end

   // Hopper model.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         chg_ack = 1'b0;
         if (!reset && (chg_dime_req || chg_nickel_req) && chg_hold == 0) begin
            if (c_wait == 0) begin
               chg_ack = 1'b1;
               c_wait  = $urandom_range(0, 3);
            end else begin
               c_wait--;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            m_vprev = 1'b0; m_cprev = 1'b0; m_gap_due = 1'b0; m_vrun = 0;
         end else begin
            m_creq = chg_dime_req | chg_nickel_req;
            if (m_gap_due) check("chg_gap_reqs_low", int'(m_creq), 0);
            m_gap_due = m_creq && chg_ack;
            if (vend_req && !m_vprev) begin
               check("vend_expected", int'(exp_vend_q.size() > 0), 1);
               if (exp_vend_q.size() > 0) check("vend_credit", int'(credit), exp_vend_q.pop_front());
            end
            if (vend_req) m_vrun++;
            else begin
               if (m_vprev) m_last_run = m_vrun;
               m_vrun = 0;
            end
            if (m_creq && !m_cprev) begin
               check("chg_both_reqs", int'(chg_dime_req & chg_nickel_req), 0);
               check("chg_expected", int'(exp_chg_q.size() > 0), 1);
               if (exp_chg_q.size() > 0) check("chg_coin", chg_dime_req ? 2 : 1, exp_chg_q.pop_front());
            end
            if (coin_reject) begin
               check("reject_expected", int'(exp_rej_q.size() > 0), 1);
               if (exp_rej_q.size() > 0) void'(exp_rej_q.pop_front());
            end
            if (vend_fault) begin
               check("fault_expected", int'(exp_fault_q.size() > 0), 1);
               if (exp_fault_q.size() > 0) void'(exp_fault_q.pop_front());
               check("fault_vend_cycles", m_last_run, VT);
            end
            m_vprev = vend_req;
            m_cprev = m_creq;
         end
      end
   end

   task automatic push_change(input int amt);
      int a;
      a = amt;
      while (a >= 2) begin
         exp_chg_q.push_back(2);
         a -= 2;
      end
      if (a == 1) exp_chg_q.push_back(1);
   endtask

   // Called at posedge+1; drives for exactly one sampling edge, returns at posedge+1.
   task automatic pulse(input logic n, input logic d, input logic q, input logic c);
      nickel = n; dime = d; quarter = q; cancel = c;
      @(posedge clk);
      #1;
      nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && busy; i++) begin
         @(posedge clk);
         #1;
      end
      check("idle_within_budget", int'(busy), 0);
   endtask

   task automatic coin(input int k, input bit with_cancel, input bit reject_follow);
      int nw;
      int k2;
      nw = model_credit + coin_vals[k];
      if (nw >= PRICE) begin
         exp_vend_q.push_back(nw - PRICE);
         push_change(nw - PRICE);
         model_credit = 0;
         if (reject_follow) exp_rej_q.push_back(1);
         pulse(k == 0, k == 1, k == 2, with_cancel);
         if (reject_follow) begin
            k2 = $urandom_range(0, 2);
            pulse(k2 == 0, k2 == 1, k2 == 2, 1'b0);
         end
         wait_idle();
         check("credit_after_vend", int'(credit), 0);
      end else begin
         model_credit = nw;
         pulse(k == 0, k == 1, k == 2, with_cancel);
         check("credit_after_coin", int'(credit), nw);
         check("busy_after_coin", int'(busy), 0);
      end
   endtask

   task automatic do_cancel(input bit reject_follow);
      if (model_credit > 0) begin
         push_change(model_credit);
         model_credit = 0;
         if (reject_follow) exp_rej_q.push_back(1);
         pulse(1'b0, 1'b0, 1'b0, 1'b1);
         check("busy_on_refund", int'(busy), 1);
         if (reject_follow) pulse(1'b0, 1'b0, 1'b1, 1'b0);
         wait_idle();
         check("credit_after_refund", int'(credit), 0);
      end else begin
         pulse(1'b0, 1'b0, 1'b0, 1'b1);
         check("cancel_zero_busy", int'(busy), 0);
      end
   endtask

   task automatic double_coin(input int k);
      int k2;
      k2 = (k + 1) % 3;
      exp_rej_q.push_back(1);
      pulse(k == 0 || k2 == 0, k == 1 || k2 == 1, k == 2 || k2 == 2, 1'b0);
      check("credit_after_double", int'(credit), model_credit);
      check("busy_after_double", int'(busy), 0);
   endtask

   initial begin
      #12;
      check("rst_vend_req", int'(vend_req), 0);
      check("rst_chg_dime", int'(chg_dime_req), 0);
      check("rst_chg_nickel", int'(chg_nickel_req), 0);
      check("rst_coin_reject", int'(coin_reject), 0);
      check("rst_vend_fault", int'(vend_fault), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_credit", int'(credit), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed openers.
      coin(2, 1'b0, 1'b0);                                          // quarter: exact vend
      coin(1, 1'b0, 1'b0); coin(1, 1'b0, 1'b0); coin(1, 1'b0, 1'b0); // dimes: vend + nickel change
      coin(1, 1'b0, 1'b0); coin(2, 1'b0, 1'b1);                      // dime+quarter: dime change, reject in VEND
      coin(0, 1'b0, 1'b0); coin(1, 1'b0, 1'b0); do_cancel(1'b1);     // refund dime+nickel, reject in refund
      double_coin(0);
      do_cancel(1'b0);

      for (int t = 0; t < 40; t++) begin
         r_sel = $urandom_range(0, 9);
         k_sel = $urandom_range(0, 2);
         if (r_sel <= 5)      coin(k_sel, 1'b0, $urandom_range(0, 2) == 0);
         else if (r_sel == 6) double_coin(k_sel);
         else if (r_sel == 7) do_cancel($urandom_range(0, 1) == 1);
         else if (r_sel == 8) coin(k_sel, 1'b1, 1'b0);
         else repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      // Vend timeout: whole price plus outstanding change refunded.
      do_cancel(1'b0);
      vend_hold = 1;
      exp_vend_q.push_back(0);
      exp_fault_q.push_back(1);
      push_change(PRICE);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle();
      check("credit_after_timeout", int'(credit), 0);

      // Ack on the last cycle before timeout wins: no fault, no refund.
      vend_hold = 2;
      exp_vend_q.push_back(0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle();
      check("credit_after_late_ack", int'(credit), 0);
      vend_hold = 0;

      // Asynchronous reset while a dime request is outstanding.
      chg_hold = 1;
      coin(1, 1'b0, 1'b0);
      coin(1, 1'b0, 1'b0);
      exp_chg_q.push_back(2);
      model_credit = 0;
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("dime_req_held", int'(chg_dime_req), 1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_vend_req", int'(vend_req), 0);
      check("arst_chg_dime", int'(chg_dime_req), 0);
      check("arst_chg_nickel", int'(chg_nickel_req), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_credit", int'(credit), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      chg_hold = 0;
      repeat (5) begin @(posedge clk); #1; end
      check("post_arst_busy", int'(busy), 0);
      check("post_arst_credit", int'(credit), 0);

      repeat (3) begin @(posedge clk); #1; end
      check("vend_q_drained", exp_vend_q.size(), 0);
      check("chg_q_drained", exp_chg_q.size(), 0);
      check("reject_q_drained", exp_rej_q.size(), 0);
      check("fault_q_drained", exp_fault_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
